// File: rtl/vga_capture_if.sv
// Bundles the sync/colour inputs and the captured-pixel outputs of vga_capture.
// Latency: n/a (wiring only).
// Backpressure: none; the video stream is free-running.
//
// Signals:
//   hsync_i, vsync_i   active-low sync from the video source
//   r_i, g_i, b_i      4-bit colour components
//   pix_valid          pix_x / pix_y / pix_rgb hold an active pixel
//   pix_x, pix_y       active column / row
//   pix_rgb            {r,g,b} of the pixel
//   line_start         single-cycle pulse per detected hsync fall
//   frame_start        single-cycle pulse per detected vsync fall
//   locked             incoming timing matches the configured raster
//   sync_err           single-cycle pulse on a timing violation
// master = video source side, slave = capture block.
interface vga_capture_if;
  logic        hsync_i;
  logic        vsync_i;
  logic [3:0]  r_i;
  logic [3:0]  g_i;
  logic [3:0]  b_i;
  logic        pix_valid;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic [11:0] pix_rgb;
  logic        line_start;
  logic        frame_start;
  logic        locked;
  logic        sync_err;

  modport master (
    output hsync_i, vsync_i, r_i, g_i, b_i,
    input  pix_valid, pix_x, pix_y, pix_rgb,
    input  line_start, frame_start, locked, sync_err
  );

  modport slave (
    input  hsync_i, vsync_i, r_i, g_i, b_i,
    output pix_valid, pix_x, pix_y, pix_rgb,
    output line_start, frame_start, locked, sync_err
  );
endinterface

// File: rtl/vga_capture.sv
// Recovers pixel coordinates from VGA-style sync, checks the raster against the parameters, reports lock.
// Latency: 2 clk from r/g/b to pix_rgb; line_start/frame_start/sync_err/locked 1 clk after the edge-detect cycle.
// Backpressure: none; the pixel stream is free-running and cannot be stalled.
//
// Ports:
//   clk    pixel clock; sync and colour inputs are synchronous to it
//   clr_n  asynchronous active-low reset
//   vif    vga_capture_if.slave: hsync_i/vsync_i/r_i/g_i/b_i in;
//          pix_valid/pix_x/pix_y/pix_rgb, line_start, frame_start, locked, sync_err out
module vga_capture #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int H_ACT_START = 144,
  parameter int H_ACT_END   = 784,
  parameter int V_ACT_START = 35,
  parameter int V_ACT_END   = 515
) (
  input  logic         clk,
  input  logic         clr_n,
  vga_capture_if.slave vif
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [9:0] CNT_MAX = 10'd1023;
  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_AS    = 10'(H_ACT_START);
  localparam logic [9:0] H_AE    = 10'(H_ACT_END);
  localparam logic [9:0] V_AS    = 10'(V_ACT_START);
  localparam logic [9:0] V_AE    = 10'(V_ACT_END);

  // ------------------------------------------------------------------
  // Input stage S1 and delayed sync copy S2. Sync bits idle high so a
  // reset does not fabricate a falling edge.
  // ------------------------------------------------------------------
  logic        hs_s1;
  logic        vs_s1;
  logic        hs_s2;
  logic        vs_s2;
  logic [11:0] rgb_s1;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      hs_s1  <= 1'b1;
      vs_s1  <= 1'b1;
      hs_s2  <= 1'b1;
      vs_s2  <= 1'b1;
      rgb_s1 <= '0;
    end else begin
      hs_s1  <= vif.hsync_i;
      vs_s1  <= vif.vsync_i;
      hs_s2  <= hs_s1;
      vs_s2  <= vs_s1;
      rgb_s1 <= {vif.r_i, vif.g_i, vif.b_i};
    end
  end

  logic h_fall;
  logic v_fall;

  assign h_fall = ~hs_s1 & hs_s2;
  assign v_fall = ~vs_s1 & vs_s2;

  // ------------------------------------------------------------------
  // Raster counters. Both saturate so a lost sync parks them at 1023,
  // which can never match a legal period and so flags the next edge.
  // ------------------------------------------------------------------
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      h_cnt <= '0;
    end else if (h_fall) begin
      h_cnt <= '0;
    end else if (h_cnt != CNT_MAX) begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  // A vsync fall wins over the hsync-driven increment when both coincide.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      v_cnt <= '0;
    end else if (v_fall) begin
      v_cnt <= '0;
    end else if (h_fall && (v_cnt != CNT_MAX)) begin
      v_cnt <= v_cnt + 10'd1;
    end
  end

  // Period checks are evaluated against the count reached just before the reload.
  logic line_bad;
  logic frame_bad;

  assign line_bad  = h_fall && (h_cnt != H_LAST);
  assign frame_bad = v_fall && (v_cnt != V_LAST);

  // ------------------------------------------------------------------
  // Lock FSM
  // ------------------------------------------------------------------
  state_t state;
  state_t state_nxt;
  logic   bad_line;
  logic   bad_line_nxt;
  logic   sync_err_nxt;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state    <= SEARCH;
      bad_line <= 1'b0;
    end else begin
      state    <= state_nxt;
      bad_line <= bad_line_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    bad_line_nxt = bad_line;
    sync_err_nxt = 1'b0;
    case (state)
      SEARCH: begin
        // Timing is not trusted yet: violations are silently ignored.
        if (v_fall) begin
          state_nxt    = CHECK;
          bad_line_nxt = 1'b0;
        end
      end
      CHECK: begin
        if (line_bad) begin
          bad_line_nxt = 1'b1;
        end
        if (v_fall) begin
          // A bad line landing on the closing vsync edge also spoils the frame.
          if (!frame_bad && !bad_line && !line_bad) begin
            state_nxt = LOCKED;
          end else begin
            sync_err_nxt = 1'b1;
          end
          bad_line_nxt = 1'b0;
        end
      end
      LOCKED: begin
        if (line_bad || frame_bad) begin
          state_nxt    = SEARCH;
          sync_err_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt    = SEARCH;
        bad_line_nxt = 1'b0;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Registered outputs. locked follows the next-state so it drops in the
  // same cycle as the sync_err pulse.
  // ------------------------------------------------------------------
  logic act_win;

  assign act_win = (state == LOCKED) &&
                   (h_cnt >= H_AS) && (h_cnt < H_AE) &&
                   (v_cnt >= V_AS) && (v_cnt < V_AE);

  logic        pix_valid_q;
  logic [9:0]  pix_x_q;
  logic [8:0]  pix_y_q;
  logic [11:0] pix_rgb_q;
  logic        line_start_q;
  logic        frame_start_q;
  logic        locked_q;
  logic        sync_err_q;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      pix_valid_q   <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      pix_rgb_q     <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      locked_q      <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      pix_valid_q   <= act_win;
      // Coordinates and colour are forced to zero outside the active window.
      pix_x_q       <= act_win ? (h_cnt - H_AS) : 10'd0;
      pix_y_q       <= act_win ? 9'(v_cnt - V_AS) : 9'd0;
      pix_rgb_q     <= act_win ? rgb_s1 : 12'd0;
      line_start_q  <= h_fall;
      frame_start_q <= v_fall;
      locked_q      <= (state_nxt == LOCKED);
      sync_err_q    <= sync_err_nxt;
    end
  end

  assign vif.pix_valid   = pix_valid_q;
  assign vif.pix_x       = pix_x_q;
  assign vif.pix_y       = pix_y_q;
  assign vif.pix_rgb     = pix_rgb_q;
  assign vif.line_start  = line_start_q;
  assign vif.frame_start = frame_start_q;
  assign vif.locked      = locked_q;
  assign vif.sync_err    = sync_err_q;

endmodule

// File: tb/tb_vga_capture.sv
// Testbench for vga_capture on a reduced 40x20 raster (24x14 active window).
// Stimulus pushes expected pixels/events into queues; a negedge monitor pops and compares.
module tb_vga_capture;

  localparam int H_TOTAL  = 40;
  localparam int V_TOTAL  = 20;
  localparam int H_AS     = 8;
  localparam int H_AE     = 32;
  localparam int V_AS     = 3;
  localparam int V_AE     = 17;
  localparam int HS_W     = 4;
  localparam int VS_LINES = 2;
  localparam int RST_GX   = 20;
  localparam int ALL_ROWS = 1000;
  localparam int NO_LIM   = 100000;

  logic clk   = 1'b0;
  logic clr_n = 1'b1;

  vga_capture_if vif();

  vga_capture #(
    .H_TOTAL    (H_TOTAL),
    .V_TOTAL    (V_TOTAL),
    .H_ACT_START(H_AS),
    .H_ACT_END  (H_AE),
    .V_ACT_START(V_AS),
    .V_ACT_END  (V_AE)
  ) dut (
    .clk  (clk),
    .clr_n(clr_n),
    .vif  (vif)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int x;
    int y;
    int rgb;
  } pix_t;

  typedef struct {
    int cyc;
    int val;
  } lk_t;

  pix_t pix_q[$];
  int   ls_q[$];
  int   fs_q[$];
  int   se_q[$];
  lk_t  lk_q[$];

  int   n_checks = 0;
  int   n_errors = 0;
  logic prev_locked = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_pix_valid"}, vif.pix_valid, 0);
    chk({tag, "_pix_x"}, vif.pix_x, 0);
    chk({tag, "_pix_y"}, vif.pix_y, 0);
    chk({tag, "_pix_rgb"}, vif.pix_rgb, 0);
    chk({tag, "_line_start"}, vif.line_start, 0);
    chk({tag, "_frame_start"}, vif.frame_start, 0);
    chk({tag, "_locked"}, vif.locked, 0);
    chk({tag, "_sync_err"}, vif.sync_err, 0);
    chk({tag, "_h_cnt"}, dut.h_cnt, 0);
    chk({tag, "_v_cnt"}, dut.v_cnt, 0);
    chk({tag, "_hs_s1"}, dut.hs_s1, 1);
    chk({tag, "_vs_s2"}, dut.vs_s2, 1);
  endtask

  task automatic drive(input int gx, input bit hs, input bit vs);
    @(posedge clk);
    #1;
    vif.hsync_i = hs;
    vif.vsync_i = vs;
    vif.r_i     = gx[3:0];
    vif.g_i     = gx[3:0];
    vif.b_i     = gx[3:0];
  endtask

  // One raster line. Input driven in cycle c reaches the outputs in cycle c+2;
  // the DUT column of input gx is gx-1 (the count reloads one cycle after the fall is seen).
  task automatic gen_line(input int gy, input int len, input int plim, input int rst_gx,
                          input bit ev_se, input bit ev_lk, input bit lk_val);
    for (int gx = 0; gx < len; gx++) begin
      drive(gx, gx >= HS_W, gy >= VS_LINES);
      if (gx == 0) begin
        ls_q.push_back(cyc + 2);
        if (gy == 0) fs_q.push_back(cyc + 2);
        if (ev_se) se_q.push_back(cyc + 2);
        if (ev_lk) begin
          lk_t l;
          l.cyc = cyc + 2;
          l.val = int'(lk_val);
          lk_q.push_back(l);
        end
      end
      if (gx < plim && gy >= V_AS && gy < V_AE && (gx - 1) >= H_AS && (gx - 1) < H_AE) begin
        pix_t p;
        p.cyc = cyc + 2;
        p.x   = gx - 1 - H_AS;
        p.y   = gy - V_AS;
        p.rgb = (gx % 16) * 273;
        pix_q.push_back(p);
      end
      if (gx == len - 1 && len > 1100) chk("h_cnt_saturated", dut.h_cnt, 1023);
      if (gx == rst_gx) begin
        lk_t l;
        clr_n = 1'b0;
        l.cyc = cyc;
        l.val = 0;
        lk_q.push_back(l);
        #1;
        chk_outputs_zero("midline_reset");
      end
      if (rst_gx >= 0 && gx == rst_gx + 3) clr_n = 1'b1;
    end
  endtask

  task automatic gen_frame(input int nlines, input int pix_rows, input int sp_line, input int sp_len,
                           input int ev_line, input bit ev_se, input bit ev_lk, input bit lk_val,
                           input int rst_line);
    for (int gy = 0; gy < nlines; gy++) begin
      int len;
      int plim;
      int rgx;
      len  = (gy == sp_line) ? sp_len : H_TOTAL;
      plim = (gy < pix_rows) ? NO_LIM : 0;
      rgx  = -1;
      if (gy == rst_line) begin
        plim = RST_GX - 2;
        rgx  = RST_GX;
      end
      gen_line(gy, len, plim, rgx, ev_se && (gy == ev_line), ev_lk && (gy == ev_line), lk_val);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (clr_n) begin
      if (vif.pix_valid) begin
        chk("pix_expected", pix_q.size() > 0, 1);
        if (pix_q.size() > 0) begin
          pix_t p;
          p = pix_q.pop_front();
          chk("pix_cyc", cyc, p.cyc);
          chk("pix_x", vif.pix_x, p.x);
          chk("pix_y", vif.pix_y, p.y);
          chk("pix_rgb", vif.pix_rgb, p.rgb);
        end
      end else begin
        chk("idle_pix_zero", {vif.pix_x, vif.pix_y, vif.pix_rgb}, 0);
      end
      if (vif.line_start) begin
        chk("line_start_expected", ls_q.size() > 0, 1);
        if (ls_q.size() > 0) chk("line_start_cyc", cyc, ls_q.pop_front());
      end
      if (vif.frame_start) begin
        chk("frame_start_expected", fs_q.size() > 0, 1);
        if (fs_q.size() > 0) chk("frame_start_cyc", cyc, fs_q.pop_front());
        chk("frame_with_line_start", vif.line_start, 1);
        chk("frame_h_cnt_zero", dut.h_cnt, 0);
        chk("frame_v_cnt_zero", dut.v_cnt, 0);
      end
      if (vif.sync_err) begin
        chk("sync_err_expected", se_q.size() > 0, 1);
        if (se_q.size() > 0) chk("sync_err_cyc", cyc, se_q.pop_front());
      end
    end
    if (vif.locked !== prev_locked) begin
      chk("locked_change_expected", lk_q.size() > 0, 1);
      if (lk_q.size() > 0) begin
        lk_t l;
        l = lk_q.pop_front();
        chk("locked_change_cyc", cyc, l.cyc);
        chk("locked_value", vif.locked, l.val);
      end
      prev_locked = vif.locked;
    end
  end

  initial begin
    vif.hsync_i = 1'b1;
    vif.vsync_i = 1'b1;
    vif.r_i     = 4'd0;
    vif.g_i     = 4'd0;
    vif.b_i     = 4'd0;
    #2;
    clr_n = 1'b0;
    #1;
    chk_outputs_zero("reset");
    repeat (3) @(posedge clk);
    #1;
    clr_n = 1'b1;

    // nlines, pix_rows, sp_line, sp_len, ev_line, ev_se, ev_lk, lk_val, rst_line
    gen_frame(V_TOTAL, 0,        -1, 0,    -1, 0, 0, 0, -1); // SEARCH -> CHECK
    gen_frame(V_TOTAL, ALL_ROWS, -1, 0,     0, 0, 1, 1, -1); // CHECK -> LOCKED
    gen_frame(V_TOTAL, ALL_ROWS, -1, 0,    -1, 0, 0, 0, -1); // locked frame
    gen_frame(V_TOTAL, 6,         5, 39,    6, 1, 1, 0, -1); // short line -> SEARCH
    gen_frame(V_TOTAL, 0,        -1, 0,    -1, 0, 0, 0, -1);
    gen_frame(V_TOTAL, ALL_ROWS, -1, 0,     0, 0, 1, 1, -1); // relock
    gen_frame(V_TOTAL, 6,         5, 1504,  6, 1, 1, 0, -1); // hsync high 1500 clk
    gen_frame(V_TOTAL, 0,        -1, 0,    -1, 0, 0, 0, -1);
    gen_frame(V_TOTAL, ALL_ROWS, -1, 0,     0, 0, 1, 1, -1);
    gen_frame(V_TOTAL, 9,        -1, 0,    -1, 0, 0, 0,  8); // reset mid active line
    gen_frame(V_TOTAL, 0,        -1, 0,    -1, 0, 0, 0, -1);
    gen_frame(V_TOTAL, ALL_ROWS, -1, 0,     0, 0, 1, 1, -1); // relock after reset
    gen_frame(V_TOTAL, 6,         5, 39,    6, 1, 1, 0, -1);
    gen_frame(V_TOTAL - 1, 0,    -1, 0,    -1, 0, 0, 0, -1); // enters CHECK, one line short
    gen_frame(V_TOTAL, 0,        -1, 0,     0, 1, 0, 0, -1); // bad frame: err, stay CHECK
    gen_frame(V_TOTAL, ALL_ROWS, -1, 0,     0, 0, 1, 1, -1); // LOCKED after good frame

    for (int i = 0; i < 10; i++) drive(0, 1'b1, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    chk("pix_queue_drained", pix_q.size(), 0);
    chk("line_start_queue_drained", ls_q.size(), 0);
    chk("frame_start_queue_drained", fs_q.size(), 0);
    chk("sync_err_queue_drained", se_q.size(), 0);
    chk("locked_queue_drained", lk_q.size(), 0);
    chk("final_locked", vif.locked, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    n_errors++;
    $display("FAIL watchdog: run did not complete, cyc %0d", cyc);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/vga_capture.md
VGA_CAPTURE -- requirements
Module: vga_capture

Interface
REQ-001 Parameter H_TOTAL, default 800: pixel clocks per line.
REQ-002 Parameter V_TOTAL, default 525: lines per frame.
REQ-003 Parameter H_ACT_START, default 144, and H_ACT_END, default 784 (exclusive): active pixel window in h_cnt units.
REQ-004 Parameter V_ACT_START, default 35, and V_ACT_END, default 515 (exclusive): active line window in v_cnt units.
REQ-005 clk  input  1: pixel clock; the source sync and rgb are synchronous to it; one clock domain.
REQ-006 clr_n  input  1: reset, asynchronous and active-low.
REQ-007 hsync_i, vsync_i  input  1 each: active-low horizontal and vertical sync.
REQ-008 r_i, g_i, b_i  input  4 each: pixel colour.
REQ-009 pix_valid  output  1: pix_x, pix_y and pix_rgb hold an active pixel this cycle.
REQ-010 pix_x  output  10: active column, 0..639.
REQ-011 pix_y  output  9: active row, 0..479.
REQ-012 pix_rgb  output  12: {r,g,b} of the pixel.
REQ-013 line_start, frame_start  output  1 each: single-cycle pulses on a detected hsync fall and a detected vsync fall.
REQ-014 locked  output  1: timing matches the parameters.
REQ-015 sync_err  output  1: single-cycle pulse on a timing violation.

Function
REQ-016 All inputs SHALL be registered once (stage S1); edges SHALL be detected by comparing S1 with a second delayed copy (S2). A fall is S1=0 and S2=1.
REQ-017 h_cnt (10 bit) SHALL load 0 on an hsync fall; otherwise it increments and saturates at 1023. The first low hsync sample therefore has h_cnt=0.
REQ-018 v_cnt (10 bit) SHALL load 0 on a vsync fall; otherwise it increments on each hsync fall and saturates at 1023.
REQ-019 Simultaneous hsync and vsync fall: h_cnt<=0 and v_cnt<=0. The vsync load SHALL win over the increment.
REQ-020 A line is bad if h_cnt != H_TOTAL-1 at an hsync fall. A frame is bad if v_cnt != V_TOTAL-1 at a vsync fall.
REQ-021 The FSM SHALL have states SEARCH, CHECK and LOCKED. Reset state is SEARCH.
REQ-022 SEARCH: the first vsync fall SHALL move to CHECK. Bad lines and bad frames are ignored here, and sync_err stays 0.
REQ-023 CHECK: on a vsync fall, if the frame is good and no bad line occurred since entering CHECK, move to LOCKED. Otherwise stay in CHECK, clear the bad-line flag and pulse sync_err.
REQ-024 LOCKED: any bad line or bad frame SHALL move to SEARCH and pulse sync_err in the same cycle.
REQ-025 locked SHALL equal (state==LOCKED), registered. It drops on the cycle after the violating edge.
REQ-026 pix_valid SHALL be 1 only when state==LOCKED, H_ACT_START<=h_cnt<H_ACT_END and V_ACT_START<=v_cnt<V_ACT_END.
REQ-027 Output values SHALL be pix_x=h_cnt-H_ACT_START, pix_y=v_cnt-V_ACT_START (low 9 bits) and pix_rgb from S1, all registered. When pix_valid=0, pix_x, pix_y and pix_rgb SHALL be 0.
REQ-028 Latency SHALL be exactly 2 clk from a pixel on r_i/g_i/b_i to pix_rgb. line_start and frame_start SHALL assert 1 clk after the edge-detect cycle.
REQ-029 Loss of sync SHALL be handled by saturation: with no hsync, h_cnt holds 1023. The next hsync fall is then a bad line and the REQ-023/REQ-024 rules apply.

Reset
REQ-030 While clr_n=0, all of the following SHALL be 0 immediately and asynchronously: pix_valid, pix_x, pix_y, pix_rgb, line_start, frame_start, locked and sync_err. The same applies to h_cnt, v_cnt, S1, S2 and the bad-line flag. S1 and S2 sync bits SHALL reset to 1 (idle high) and state SHALL be SEARCH.
REQ-031 Reset released mid-frame SHALL resume in SEARCH. No sync_err SHALL be produced until the FSM reaches CHECK.

Verification
REQ-032 Stimulus: the team's 800x525 timing generator, 3 frames, colour = h_cnt[3:0] replicated. Required: locked=1 after the 2nd vsync fall; 640x480 pix_valid per locked frame; first valid pixel pix_x=0, pix_y=0, rgb equal to the input 2 clk earlier.
REQ-033 Stimulus: while locked, one line shortened to 799 clocks. Required: sync_err pulse at that hsync fall, locked=0 next cycle, pix_valid=0 until relock two vsync falls later.
REQ-034 Stimulus: hsync and vsync falls in the same cycle. Required: h_cnt=0, v_cnt=0, both line_start and frame_start pulse.
REQ-035 Stimulus: hsync held high for 1500 clocks while locked. Required: h_cnt saturates at 1023, then sync_err and SEARCH at the next fall.
REQ-036 Stimulus: clr_n pulsed low mid-active-line. Required: all outputs 0 in the same cycle, state SEARCH, relock within 2 full frames.
REQ-037 Stimulus: a frame of 524 lines while in CHECK. Required: sync_err pulse, state remains CHECK, LOCKED after the next good frame.
